muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One result bit per cycle; busy stalls the pipeline until done.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic             sa;
  logic             sb;
  logic             dz;
  logic [WIDTH-1:0] opnd;
  logic [AW-1:0]    acc;

  logic             signed_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [WIDTH:0]   msum_c;
  logic [WIDTH:0]   trial_c;
  logic [AW-1:0]    prod_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

  // Launch-time operand conditioning: mult/div work on magnitudes.
  always_comb begin
    signed_c = ~op[0];
    abs_a_c  = (signed_c && a[WIDTH-1]) ? -a : a;
    abs_b_c  = (signed_c && b[WIDTH-1]) ? -b : b;
  end

  // Datapath step and final sign correction.
  // acc holds {partial, multiplier} for multiply and {rem, quot} for divide.
  always_comb begin
    msum_c  = {1'b0, acc[AW-1:WIDTH]} + {1'b0, opnd};
    trial_c = acc[AW-1:WIDTH-1] - {1'b0, opnd};
    prod_c  = (sa ^ sb) ? -acc : acc;
    quot_c  = ((sa ^ sb) && !dz) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_c   = (sa && !dz) ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      div_q <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      opnd  <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_q <= op[1];
            sa    <= signed_c & a[WIDTH-1];
            sb    <= signed_c & b[WIDTH-1];
            dz    <= op[1] & (b == '0);
            opnd  <= abs_b_c;
            acc   <= {WIDTH'(0), abs_a_c};
            cnt   <= CW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end

        S_RUN: begin
          if (div_q) begin
            // Restoring divide: keep the trial remainder only if it did not borrow.
            if (!trial_c[WIDTH]) acc <= {trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                 acc <= {acc[AW-2:0], 1'b0};
          end else begin
            if (acc[0]) acc <= {msum_c, acc[WIDTH-1:1]};
            else        acc <= {1'b0, acc[AW-1:1]};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CW'(1);
        end

        S_FIX: begin
          if (div_q) begin
            hi <= rem_c;
            lo <= quot_c;
          end else begin
            hi <= prod_c[AW-1:WIDTH];
            lo <= prod_c[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a signed/unsigned golden model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  res_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done_cnt   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t golden(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint      sx;
    longint      sy;
    res_t        r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) p = {(x[31] ? -x : x), 32'hFFFF_FFFF};
        else            p = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else            p = {x % y, x / y};
      end
    endcase
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 5));
      default: return 32'($urandom);
    endcase
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      res_t e;
      done_cnt++;
      check("pending_on_done", 64'(sbq.size() != 0), 64'(1));
      check("busy_on_done", 64'(busy), 64'(0));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_hi", 64'(hi), 64'(e.hi));
        check("sb_lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit expect_res);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_res) sbq.push_back(golden(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'($urandom);
    b     = 32'($urandom);
    op    = 2'($urandom);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1) check({tag, "_timeout"}, 64'(done), 64'(1));
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    launch(o, x, y, 1'b1);
    wait_done(tag, n);
    check({tag, "_latency"}, 64'(n), 64'(W + 1));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int n;
    int c;
    int d0;
    logic [W-1:0] hold;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // mtlo alone, then mthi+mtlo together
    mtlo = 1'b1; wdata = 32'h55;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'(32'h55));
    check("mtlo_hi", 64'(hi), 64'(0));
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", 64'(hi), 64'(32'hCAFE_F00D));
    check("mtboth_lo", 64'(lo), 64'(32'hCAFE_F00D));

    // mthi in the start cycle loses to start; hi holds during RUN
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    launch(2'b01, 32'd5, 32'd7, 1'b1);
    mthi = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("run_hold_hi", 64'(hi), 64'(32'hCAFE_F00D));
    check("run_hold_lo", 64'(lo), 64'(32'hCAFE_F00D));
    wait_done("start_wins", n);
    check("start_wins_hi", 64'(hi), 64'(0));
    check("start_wins_lo", 64'(lo), 64'(35));
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN aborts without a result
    launch(2'b01, 32'd5, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    d0 = done_cnt;
    #10;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_hi", 64'(hi), 64'(0));
    check("post_rst_lo", 64'(lo), 64'(0));
    check("post_rst_no_done", 64'(done_cnt), 64'(d0));

    // Directed arithmetic and boundary cases
    directed("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    directed("mult_neg", 2'b00, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    directed("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    directed("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    directed("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
    directed("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // mthi while busy is dropped
    @(posedge clk); #1;
    hold = hi;
    launch(2'b00, 32'd1000, -32'sd3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("busy_mthi_hold", 64'(hi), 64'(hold));
    wait_done("busy_mthi", n);
    check("busy_mthi_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    @(posedge clk); #1;

    // start during RUN is ignored and busy length is unchanged
    launch(2'b11, 32'd999, 32'd10, 1'b1);
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      c++;
      if (c == 5) begin
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("busy_len", 64'(c), 64'(W + 1));
    check("busy_len_done", 64'(done), 64'(1));

    // Back-to-back: start in the done cycle
    launch(2'b10, -32'sd100, 32'd7, 1'b1);
    wait_done("b2b_first", n);
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_done("b2b_second", n);
    check("b2b_latency", 64'(n + 1), 64'(W + 2));

    // Random ops with 0..3 idle cycles between them
    for (int i = 0; i < 1000; i++) begin
      launch(2'($urandom), pick(), pick(), 1'b1);
      wait_done("rand", n);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
